// File: rtl/tetris_pkg.sv
// tetris_pkg: shared Tetris types, board defaults and the candidate-move helper.
package tetris_pkg;

    localparam int COLS_DEF = 10;
    localparam int ROWS_DEF = 20;

    typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_WAIT, S_CHECK, S_LOCK, S_OVER} state_t;
    typedef enum logic [2:0] {MV_NONE, MV_LEFT, MV_RIGHT, MV_ROT, MV_GRAV, MV_DROP} move_t;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [1:0] rot;
    } pos_t;

    // Coordinates are carried at 8 bits; callers truncate to their own widths.
    function automatic pos_t next_candidate(input move_t mv, input logic [7:0] px,
                                            input logic [7:0] py, input logic [1:0] pr);
        return '{x:   mv == MV_LEFT ? px - 8'd1 : mv == MV_RIGHT ? px + 8'd1 : px,
                 y:   (mv == MV_GRAV || mv == MV_DROP) ? py + 8'd1 : py,
                 rot: mv == MV_ROT ? pr + 2'd1 : pr};
    endfunction

endpackage

// File: rtl/piece_drop_ctrl.sv
// piece_drop_ctrl: active-piece motion FSM; arbitrates gravity/player events,
// queries the collision checker and requests a board lock on a blocked fall.
module piece_drop_ctrl
    import tetris_pkg::*;
#(
    parameter int COLS    = COLS_DEF,
    parameter int ROWS    = ROWS_DEF,
    parameter int X_W     = 4,
    parameter int Y_W     = 5,
    parameter int SPAWN_X = 4
) (
    input  logic           CLOCK_50,
    input  logic           resetn,
    input  logic           start,
    input  logic           tick_gravity,
    input  logic           btn_left,
    input  logic           btn_right,
    input  logic           btn_rot,
    input  logic           btn_drop,
    output logic           query_valid,
    output logic [X_W-1:0] query_x,
    output logic [Y_W-1:0] query_y,
    output logic [1:0]     query_rot,
    input  logic           query_ack,
    input  logic           query_hit,
    output logic [X_W-1:0] piece_x,
    output logic [Y_W-1:0] piece_y,
    output logic [1:0]     piece_rot,
    output logic           lock_valid,
    input  logic           lock_ack,
    output logic           game_over,
    output logic           busy
);

    localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

    state_t state;
    move_t  cur_mv;
    move_t  mv;
    logic   gravity_pend;
    logic   edge_block;
    logic   floor_hit;
    pos_t   cand;

    // In CHECK the only self-issued step is the next hard-drop row.
    always_comb begin
        mv = state == S_CHECK ? MV_DROP :
             btn_drop ? MV_DROP : btn_rot ? MV_ROT : btn_left ? MV_LEFT :
             btn_right ? MV_RIGHT : (tick_gravity || gravity_pend) ? MV_GRAV : MV_NONE;
    end

    assign cand       = next_candidate(mv, 8'(piece_x), 8'(piece_y), piece_rot);
    assign edge_block = (mv == MV_LEFT && piece_x == '0) || (mv == MV_RIGHT && piece_x == X_LAST);
    assign floor_hit  = (mv == MV_GRAV || mv == MV_DROP) && piece_y == Y_LAST;
    assign busy       = !(state == S_IDLE || state == S_WAIT);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            cur_mv       <= MV_NONE;
            gravity_pend <= 1'b0;
            query_valid  <= 1'b0;
            query_x      <= '0;
            query_y      <= '0;
            query_rot    <= '0;
            piece_x      <= '0;
            piece_y      <= '0;
            piece_rot    <= '0;
            lock_valid   <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            if (tick_gravity && state != S_IDLE && state != S_OVER)
                gravity_pend <= 1'b1;
            case (state)
                S_IDLE: if (start) begin
                    gravity_pend <= 1'b0;
                    state        <= S_SPAWN;
                end
                S_SPAWN: if (!query_valid) begin
                    query_valid <= 1'b1;
                    query_x     <= X_W'(SPAWN_X);
                    query_y     <= '0;
                    query_rot   <= '0;
                end else if (query_ack) begin
                    query_valid <= 1'b0;
                    if (query_hit) begin
                        game_over <= 1'b1;
                        state     <= S_OVER;
                    end else begin
                        piece_x   <= query_x;
                        piece_y   <= query_y;
                        piece_rot <= query_rot;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mv == MV_GRAV)
                        gravity_pend <= 1'b0;
                    if (floor_hit) begin
                        lock_valid <= 1'b1;
                        state      <= S_LOCK;
                    end else if (mv != MV_NONE && !edge_block) begin
                        query_valid <= 1'b1;
                        query_x     <= X_W'(cand.x);
                        query_y     <= Y_W'(cand.y);
                        query_rot   <= cand.rot;
                        cur_mv      <= mv;
                        state       <= S_CHECK;
                    end
                end
                // query_valid low inside CHECK means a hard drop awaits its next row.
                S_CHECK: if (!query_valid) begin
                    if (floor_hit) begin
                        lock_valid <= 1'b1;
                        state      <= S_LOCK;
                    end else begin
                        query_valid <= 1'b1;
                        query_x     <= X_W'(cand.x);
                        query_y     <= Y_W'(cand.y);
                        query_rot   <= cand.rot;
                    end
                end else if (query_ack) begin
                    query_valid <= 1'b0;
                    if (!query_hit) begin
                        piece_x   <= query_x;
                        piece_y   <= query_y;
                        piece_rot <= query_rot;
                        if (cur_mv != MV_DROP)
                            state <= S_WAIT;
                    end else if (cur_mv == MV_GRAV || cur_mv == MV_DROP) begin
                        lock_valid <= 1'b1;
                        state      <= S_LOCK;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_LOCK: if (lock_ack) begin
                    lock_valid   <= 1'b0;
                    gravity_pend <= 1'b0;
                    state        <= S_SPAWN;
                end
                S_OVER: if (start) begin
                    game_over    <= 1'b0;
                    gravity_pend <= 1'b0;
                    state        <= S_SPAWN;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piece_drop_ctrl.sv
// tb_piece_drop_ctrl: directed bench for piece_drop_ctrl with a queue of expected
// checker queries that is drained as the DUT presents each query.
module tb_piece_drop_ctrl;

    typedef struct {
        int x;
        int y;
        int r;
    } exp_t;

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       tick_gravity = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_rot = 1'b0;
    logic       btn_drop = 1'b0;
    logic       query_valid;
    logic [3:0] query_x;
    logic [4:0] query_y;
    logic [1:0] query_rot;
    logic       query_ack = 1'b0;
    logic       query_hit = 1'b0;
    logic [3:0] piece_x;
    logic [4:0] piece_y;
    logic [1:0] piece_rot;
    logic       lock_valid;
    logic       lock_ack = 1'b0;
    logic       game_over;
    logic       busy;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    piece_drop_ctrl dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .tick_gravity(tick_gravity),
        .btn_left(btn_left), .btn_right(btn_right), .btn_rot(btn_rot), .btn_drop(btn_drop),
        .query_valid(query_valid), .query_x(query_x), .query_y(query_y), .query_rot(query_rot),
        .query_ack(query_ack), .query_hit(query_hit), .piece_x(piece_x), .piece_y(piece_y),
        .piece_rot(piece_rot), .lock_valid(lock_valid), .lock_ack(lock_ack),
        .game_over(game_over), .busy(busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push(input int x, input int y, input int r);
        exp_t e;
        e.x = x;
        e.y = y;
        e.r = r;
        exp_q.push_back(e);
    endtask

    task automatic serve(input logic hit, input string tag);
        exp_t e;
        for (int i = 0; i < 20 && query_valid !== 1'b1; i++) step();
        chk({tag, "_qvalid"}, 32'(query_valid), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_qx"}, 32'(query_x), e.x);
            chk({tag, "_qy"}, 32'(query_y), e.y);
            chk({tag, "_qrot"}, 32'(query_rot), e.r);
        end
        query_ack = 1'b1;
        query_hit = hit;
        step();
        query_ack = 1'b0;
        query_hit = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        step();
        step();
        chk("rst_qvalid", 32'(query_valid), 0);
        chk("rst_lock", 32'(lock_valid), 0);
        chk("rst_over", 32'(game_over), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pos", {piece_x, piece_y, piece_rot, query_x, query_y, query_rot}, 0);
        resetn = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("spawn_busy", 32'(busy), 1);
        push(4, 0, 0);
        serve(1'b0, "spawn0");
        chk("spawn_px", 32'(piece_x), 4);
        chk("spawn_py", 32'(piece_y), 0);
        chk("spawn_prot", 32'(piece_rot), 0);
        chk("wait_busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            tick_gravity = 1'b1;
            step();
            tick_gravity = 1'b0;
            push(4, i + 1, 0);
            serve(1'b0, "grav");
            chk("grav_py", 32'(piece_y), i + 1);
        end
        for (int i = 0; i < 4; i++) begin
            btn_left = 1'b1;
            step();
            btn_left = 1'b0;
            push(3 - i, 3, 0);
            serve(1'b0, "left");
        end
        chk("left_px0", 32'(piece_x), 0);
        btn_left = 1'b1;
        step();
        btn_left = 1'b0;
        chk("left_edge_qv", 32'(query_valid), 0);
        step();
        chk("left_edge_qv2", 32'(query_valid), 0);
        chk("left_edge_px", 32'(piece_x), 0);
        for (int i = 0; i < 4; i++) begin
            btn_rot = 1'b1;
            step();
            btn_rot = 1'b0;
            push(0, 3, (i + 1) % 4);
            serve(1'b0, "rot");
            chk("rot_val", 32'(piece_rot), (i + 1) % 4);
        end
        for (int i = 0; i < 2; i++) begin
            tick_gravity = 1'b1;
            step();
            tick_gravity = 1'b0;
            push(0, 4 + i, 0);
            serve(1'b0, "grav2");
        end
        chk("pre_drop_py", 32'(piece_y), 5);
        btn_drop = 1'b1;
        step();
        btn_drop = 1'b0;
        push(0, 6, 0);
        serve(1'b0, "drop6");
        chk("drop6_py", 32'(piece_y), 6);
        chk("drop6_busy", 32'(busy), 1);
        push(0, 7, 0);
        serve(1'b0, "drop7");
        chk("drop7_py", 32'(piece_y), 7);
        push(0, 8, 0);
        serve(1'b1, "drop8");
        chk("lock_valid", 32'(lock_valid), 1);
        chk("lock_py", 32'(piece_y), 7);
        chk("lock_qv", 32'(query_valid), 0);
        step();
        chk("lock_hold", 32'(lock_valid), 1);
        lock_ack = 1'b1;
        step();
        lock_ack = 1'b0;
        chk("lock_fall", 32'(lock_valid), 0);
        chk("spawn_delay_qv", 32'(query_valid), 0);
        step();
        chk("spawn_after_lock_qv", 32'(query_valid), 1);
        push(4, 0, 0);
        serve(1'b1, "spawn_hit");
        chk("over_set", 32'(game_over), 1);
        chk("over_nolock", 32'(lock_valid), 0);
        step();
        chk("over_hold", 32'(game_over), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("over_clear", 32'(game_over), 0);
        push(4, 0, 0);
        serve(1'b0, "respawn");
        tick_gravity = 1'b1;
        btn_right = 1'b1;
        step();
        tick_gravity = 1'b0;
        btn_right = 1'b0;
        push(5, 0, 0);
        serve(1'b0, "right_first");
        chk("right_px", 32'(piece_x), 5);
        chk("right_py", 32'(piece_y), 0);
        push(5, 1, 0);
        serve(1'b0, "pend_grav");
        chk("pend_py", 32'(piece_y), 1);
        btn_right = 1'b1;
        step();
        btn_right = 1'b0;
        tick_gravity = 1'b1;
        step();
        tick_gravity = 1'b0;
        step();
        tick_gravity = 1'b1;
        step();
        tick_gravity = 1'b0;
        chk("check_hold_qx", 32'(query_x), 6);
        push(6, 1, 0);
        serve(1'b0, "right_hold");
        push(6, 2, 0);
        serve(1'b0, "pend_once");
        step();
        step();
        chk("pend_single_qv", 32'(query_valid), 0);
        chk("pend_single_py", 32'(piece_y), 2);
        btn_left = 1'b1;
        step();
        btn_left = 1'b0;
        push(5, 2, 0);
        serve(1'b1, "left_hit");
        chk("left_hit_px", 32'(piece_x), 6);
        chk("left_hit_busy", 32'(busy), 0);
        btn_left = 1'b1;
        step();
        btn_left = 1'b0;
        chk("mid_qv", 32'(query_valid), 1);
        #3;
        resetn = 1'b0;
        #1;
        chk("async_qv", 32'(query_valid), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_px", 32'(piece_x), 0);
        step();
        resetn = 1'b1;
        query_ack = 1'b1;
        step();
        query_ack = 1'b0;
        step();
        chk("late_ack_px", 32'(piece_x), 0);
        chk("late_ack_qv", 32'(query_valid), 0);
        chk("late_ack_busy", 32'(busy), 0);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piece_drop_ctrl.md
# piece_drop_ctrl

Active-piece motion controller for the Tetris datapath. It sits directly downstream of the gravity tick generator and consumes its single-cycle `tick_gravity` pulse together with debounced player move pulses. Each move is proposed as a candidate position to the board collision checker over a valid/ack handshake. Legal moves are committed; a blocked downward step raises a lock request to the board writer.

## Interface
Parameters:
- `COLS`, default 10: board width in cells.
- `ROWS`, default 20: board height in cells.
- `X_W`, default 4: width of the x coordinate.
- `Y_W`, default 5: width of the y coordinate.
- `SPAWN_X`, default 4: spawn column.

Ports:
- `CLOCK_50` in 1: system clock, 50 MHz.
- `resetn` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle pulse that begins a game.
- `tick_gravity` in 1: single-cycle gravity pulse.
- `btn_left`, `btn_right`, `btn_rot`, `btn_drop` in 1 each: single-cycle player pulses.
- `query_valid` out 1: candidate position is presented.
- `query_x` out X_W, `query_y` out Y_W, `query_rot` out 2: candidate position and rotation.
- `query_ack` in 1: checker response is valid this cycle.
- `query_hit` in 1: candidate collides; sampled only when `query_ack` is high.
- `piece_x` out X_W, `piece_y` out Y_W, `piece_rot` out 2: committed piece position.
- `lock_valid` out 1: request to write the piece into the board.
- `lock_ack` in 1: board write is done.
- `game_over` out 1: level signal.
- `busy` out 1: high in every state except IDLE and WAIT.

## Operation
- States: IDLE, SPAWN, WAIT, CHECK, LOCK, OVER.
- **IDLE:** on `start`, go to SPAWN.
- **SPAWN:** load candidate (SPAWN_X, 0, 0) and issue a query.
  - ack with no hit: commit, go to WAIT.
  - ack with hit: go to OVER.
- **WAIT:** sample events in priority order: drop > rot > left > right > gravity. The highest-priority event forms the candidate; go to CHECK.
  - Lower-priority player pulses in the same cycle are discarded.
  - A gravity tick coincident with a player move is kept pending.
- **Candidates:**
  - left: x-1. right: x+1.
  - rot: (rot+1) mod 4; rot 3 wraps to 0.
  - gravity and drop: y+1.
- **Boundary handling (no query issued):**
  - left at x=0, or right at x=COLS-1: discarded, stay in WAIT.
  - gravity or drop step at y=ROWS-1: go directly to LOCK.
- **CHECK:** hold `query_valid` and the candidate stable until `query_ack`.
  - no hit: commit the candidate.
  - hit on left/right/rot: discard the candidate, return to WAIT.
  - hit on gravity or drop: go to LOCK with position unchanged.
- **Hard drop:** after each successful commit, issue y+1 again without returning to WAIT. Ends in LOCK. Player pulses during the drop are ignored.
- **LOCK:** hold `lock_valid` until `lock_ack`, then go to SPAWN.
- **OVER:** hold `game_over` high. On `start`, clear it and go to SPAWN.
- **gravity_pend:**
  - Set by `tick_gravity` in any state except IDLE and OVER.
  - One-deep: a tick arriving while already pending is dropped.
  - Cleared when gravity is serviced in WAIT, and on entry to SPAWN.
- Player pulses outside WAIT are dropped, not latched.

## Timing
- Reset values: state IDLE; all outputs 0; gravity_pend 0.
- Event sampled in WAIT at edge N: `query_valid` is high from cycle N+1.
- `query_ack` may arrive in the same cycle `query_valid` rises. Minimum event-to-commit latency is 2 cycles.
- Committed position updates on the edge that samples `query_ack`.
- Candidate outputs change only on the edge that raises `query_valid`.
- `lock_valid` rises on the edge after the blocked step. It falls on the edge that samples `lock_ack`. The SPAWN query follows one cycle later.
- Reset mid-operation: `query_valid` and `lock_valid` drop asynchronously; any in-flight ack afterwards is ignored.
- Position arithmetic is unsigned X_W/Y_W; underflow and overflow are prevented by the boundary rules above.

## Structure
- Shared package `tetris_pkg`:
  - state enum;
  - move-code enum (NONE, LEFT, RIGHT, ROT, GRAV, DROP);
  - default COLS/ROWS constants;
  - pure function `next_candidate(move, x, y, rot)`.
- Single module; no sub-module. Event arbitration and the FSM stay in one file.

## Test plan
- Reset, `start`, ack with no hit → `piece_x`=4, `piece_y`=0, `piece_rot`=0, `busy`=0. Then 3 gravity ticks, each acked with no hit → `piece_y`=3.
- At `piece_x`=0, pulse `btn_left` → no `query_valid`, x stays 0. Pulse `btn_rot` four times, all acked with no hit → rot sequence 1, 2, 3, 0.
- At y=5, pulse `btn_drop`; checker reports hit for y=8 → commits y=6 and y=7, `lock_valid` with `piece_y`=7. `lock_ack` → SPAWN query at (4, 0, 0).
- Spawn query acked with hit → `game_over`=1, no `lock_valid`. `start` → `game_over`=0, new spawn query issued.
- `tick_gravity` and `btn_right` in the same WAIT cycle → right query first; gravity query on the next WAIT visit. A tick during CHECK is serviced after CHECK; two ticks during one CHECK yield a single y+1.
- Assert `resetn` low while `query_valid`=1 → all outputs 0 immediately, state IDLE. A late `query_ack` after release has no effect.
